// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the issue-register payload type for the operand-fetch stage.
package riscv_pkg;

  localparam int REG_AW = 5;
  localparam int WORD_W = 32;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_ILL = 2'd2
  } fmt_e;

  typedef struct packed {
    logic              i_en;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [WORD_W-1:0] rs1;
    logic [WORD_W-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } issue_t;

  // Only OP and OP-IMM are executed; R-type must carry a base or alternate funct7.
  function automatic fmt_e decode_fmt(input logic [6:0] opcode, input logic [6:0] funct7);
    fmt_e f;
    f = FMT_ILL;
    if (opcode == OPC_OP_IMM) begin
      f = FMT_I;
    end else if (opcode == OPC_OP && (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT)) begin
      f = FMT_R;
    end
    return f;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in, ALU-issue-out and writeback channels of the operand-fetch stage.
interface operand_fetch_if #(
  parameter int XLEN = 32
);
  import riscv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;

  logic              out_valid;
  logic              out_ready;
  logic              out_i_en;
  logic [2:0]        out_funct3;
  logic [6:0]        out_funct7;
  logic [XLEN-1:0]   out_rs1;
  logic [XLEN-1:0]   out_rs2;
  logic [REG_AW-1:0] out_rd;

  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  logic              illegal;

  // Stage side
  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_i_en, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, illegal
  );

  // Fetch/ALU/writeback side
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_i_en, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, illegal
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module reg_file_2r1w #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/operand_fetch.sv
// RV32I OP/OP-IMM decode and operand fetch with writeback bypass, RAW/WAW scoreboard and a
// single-entry issue register feeding the ALU.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);

  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] imm);
    logic signed [11:0] s;
    s = $signed(imm);
    return XLEN'(s);
  endfunction

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  fmt_e              fmt;
  logic              is_r, legal;

  logic [XLEN-1:0]   rf_rd1, rf_rd2;
  logic [XLEN-1:0]   op1, op2;
  logic signed [XLEN-1:0] imm_sx;

  logic [NREGS-1:0]  pending, pending_n, clr_mask, set_mask, pend_eff;
  logic              hazard, accept, issue;

  issue_t            iss_p1;
  logic              vld_p1, ill_p1;

  always_comb begin
    opcode  = bus.in_instr[6:0];
    rd_idx  = bus.in_instr[11:7];
    funct3  = bus.in_instr[14:12];
    rs1_idx = bus.in_instr[19:15];
    rs2_idx = bus.in_instr[24:20];
    funct7  = bus.in_instr[31:25];
    fmt     = decode_fmt(opcode, funct7);
    is_r    = (fmt == FMT_R);
    legal   = (fmt != FMT_ILL);
    imm_sx  = sext12(bus.in_instr[31:20]);
  end

  reg_file_2r1w #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .AW    (REG_AW)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_idx),
    .rd1 (rf_rd1),
    .ra2 (rs2_idx),
    .rd2 (rf_rd2),
    .we  (bus.wb_en),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

  // Writeback lands this cycle, so forward it instead of waiting for the regfile.
  always_comb begin
    op1 = rf_rd1;
    if (bus.wb_en && bus.wb_addr == rs1_idx && rs1_idx != '0) begin
      op1 = bus.wb_data;
    end
    op2 = rf_rd2;
    if (bus.wb_en && bus.wb_addr == rs2_idx && rs2_idx != '0) begin
      op2 = bus.wb_data;
    end
    if (!is_r) begin
      op2 = imm_sx;
    end
  end

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (bus.wb_en) begin
      clr_mask = NREGS'(1) << bus.wb_addr;
    end
    pend_eff = pending & ~clr_mask;
    hazard   = legal & (pend_eff[rs1_idx] | (is_r & pend_eff[rs2_idx]) | pend_eff[rd_idx]);
    bus.in_ready = (~vld_p1 | bus.out_ready) & ~hazard & ~rst;
    accept   = bus.in_valid & bus.in_ready;
    issue    = accept & legal;
    if (issue && rd_idx != '0) begin
      set_mask = NREGS'(1) << rd_idx;
    end
    // A new writer claiming the register outranks a same-cycle release.
    pending_n    = pend_eff | set_mask;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_n;
    end
  end

  // Stage boundary: issue register toward the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      iss_p1 <= '0;
    end else begin
      ill_p1 <= accept & ~legal;
      if (issue) begin
        vld_p1        <= 1'b1;
        iss_p1.i_en   <= ~is_r;
        iss_p1.funct3 <= funct3;
        iss_p1.funct7 <= funct7;
        iss_p1.rs1    <= op1;
        iss_p1.rs2    <= op2;
        iss_p1.rd     <= rd_idx;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_i_en   = iss_p1.i_en;
  assign bus.out_funct3 = iss_p1.funct3;
  assign bus.out_funct7 = iss_p1.funct7;
  assign bus.out_rs1    = iss_p1.rs1;
  assign bus.out_rs2    = iss_p1.rs2;
  assign bus.out_rd     = iss_p1.rd;
  assign bus.illegal    = ill_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: decode, bypass, scoreboard stalls, backpressure, illegal drop, reset.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(32)) bus ();

  operand_fetch #(.NREGS(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are also checked there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic ien, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    chk({tag, ".valid"},  32'(bus.out_valid),  32'd1);
    chk({tag, ".i_en"},   32'(bus.out_i_en),   32'(ien));
    chk({tag, ".funct3"}, 32'(bus.out_funct3), 32'(f3));
    chk({tag, ".funct7"}, 32'(bus.out_funct7), 32'(f7));
    chk({tag, ".rs1"},    bus.out_rs1,         a);
    chk({tag, ".rs2"},    bus.out_rs2,         b);
    chk({tag, ".rd"},     32'(bus.out_rd),     32'(rd));
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b1;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    @(negedge clk);
    tick();
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.illegal",   32'(bus.illegal),   32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst.out_rs1",   bus.out_rs1,        32'd0);
    rst = 1'b0;
    #1 chk("rst.release_ready", 32'(bus.in_ready), 32'd1);

    // 1: add x3,x1,x2 after writing x1=5, x2=7
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5;
    tick();
    bus.wb_addr = 5'd2; bus.wb_data = 32'd7;
    tick();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3;
    #1 chk("add.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("add", 1'b0, 3'd0, 7'h00, 32'd5, 32'd7, 5'd3);
    tick();
    chk("add.drain", 32'(bus.out_valid), 32'd0);

    // 2: addi x4,x0,-1 then srai x5,x4,3 stalls on x4 until bypassed writeback
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFF00213;
    tick();
    chk_out("addi", 1'b1, 3'd0, 7'h7F, 32'd0, 32'hFFFFFFFF, 5'd4);
    bus.in_instr = 32'h40325293;
    #1 chk("srai.stall0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("srai.stall_valid", 32'(bus.out_valid), 32'd0);
    chk("srai.stall1", 32'(bus.in_ready), 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h80000010;
    #1 chk("srai.release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    chk_out("srai", 1'b1, 3'd5, 7'h20, 32'h80000010, 32'h00000403, 5'd5);
    tick();

    // 3: backpressure holds the issue register, then one op per cycle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00208433;   // add x8,x1,x2
    tick();
    bus.in_instr = 32'h402084B3;                         // sub x9,x1,x2
    for (int i = 0; i < 3; i++) begin
      chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold.rd", 32'(bus.out_rd), 32'd8);
      chk("hold.valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("hold.release", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("sub", 1'b0, 3'd0, 7'h20, 32'd5, 32'd7, 5'd9);
    bus.in_instr = 32'h00114533;                         // xor x10,x2,x1
    tick();
    chk_out("xor", 1'b0, 3'd4, 7'h00, 32'd7, 32'd5, 5'd10);
    bus.in_valid = 1'b0;
    tick();
    chk("xor.drain", 32'(bus.out_valid), 32'd0);

    // 4: illegal instructions are consumed, pulse illegal, never issue or mark pending
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000603;   // load, rd=x12
    #1 chk("ld.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("ld.illegal", 32'(bus.illegal), 32'd1);
    chk("ld.valid", 32'(bus.out_valid), 32'd0);
    bus.in_instr = 32'h020082B3;                         // funct7=01, rd=x5 still pending
    #1 chk("f7.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("f7.illegal", 32'(bus.illegal), 32'd1);
    chk("f7.valid", 32'(bus.out_valid), 32'd0);
    bus.in_instr = 32'h00060693;                         // addi x13,x12,0
    #1 chk("ld.no_pending", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("ill.pulse_end", 32'(bus.illegal), 32'd0);
    chk_out("addi13", 1'b1, 3'd0, 7'h00, 32'd0, 32'd0, 5'd13);
    tick();

    // Write to x0 is ignored and never bypassed
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'd55;
    bus.in_valid = 1'b1; bus.in_instr = 32'h000007B3;   // add x15,x0,x0
    tick();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    chk_out("x0", 1'b0, 3'd0, 7'h00, 32'd0, 32'd0, 5'd15);
    tick();

    // 5: WAW on x6, then reset while an op is held
    bus.in_valid = 1'b1; bus.in_instr = 32'h00208333;   // add x6,x1,x2
    tick();
    #1 chk("waw.stall0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("waw.stall1", 32'(bus.in_ready), 32'd0);
    chk("waw.stall_valid", 32'(bus.out_valid), 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h123;
    #1 chk("waw.release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk_out("waw", 1'b0, 3'd0, 7'h00, 32'd5, 32'd7, 5'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.valid", 32'(bus.out_valid), 32'd0);
    chk("mrst.illegal", 32'(bus.illegal), 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00608733;   // add x14,x1,x6
    #1 chk("mrst.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("mrst", 1'b0, 3'd0, 7'h00, 32'd0, 32'd0, 5'd14);
    bus.out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
